// File: rtl/bank_load_ctrl.sv
// bank_load_ctrl: write sequencer for the activation memory banks.
//
// Accepts a byte stream over a valid/ready handshake and interleaves the bytes
// round-robin across NUM_BANKS banks. Byte i of a load goes to bank (i mod
// NUM_BANKS) at word address (base_addr + i / NUM_BANKS) mod DATA_DEPTH.
// One load command is sequenced at a time; completion is a one-cycle done pulse.
//
// Optional feature macro: BANK_LOAD_CHECKSUM_EN adds a 16-bit running sum of
// the accepted bytes (port checksum). Without it the port and adder are absent.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr,   load command (accepted only in IDLE); base word
//   len                 address and byte count captured on start
//   abort               cancel the current load, no done pulse
//   in_valid, in_data,  byte stream handshake
//   in_ready
//   wr_addr, wr_data,   registered bank write port (addr_b, data_b, wrenb)
//   wren, bank_cs       and one-hot chip select
//   busy                high when not IDLE
//   done                one-cycle pulse at the end of a load
//   wrap_err            sticky: a write address wrapped past DATA_DEPTH-1
//   checksum            (optional) mod-2^16 sum of bytes since last start
module bank_load_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned NUM_BANKS  = 5,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wren,
  output logic [NUM_BANKS-1:0]  bank_cs,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap_err
`ifdef BANK_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int unsigned SUM_W  = ADDR_WIDTH + 1;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [SUM_W-1:0]     DEPTH_S   = SUM_W'(DATA_DEPTH);
  localparam logic [BANK_W-1:0]    LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [NUM_BANKS-1:0] CS_ONE    = NUM_BANKS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [SUM_W-1:0]      word_q, word_d;

  logic                  ready_d, busy_d, done_d, wren_d, wrap_d;
  logic [NUM_BANKS-1:0]  cs_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;

  logic                  hs;
  logic [SUM_W-1:0]      addr_full;
  logic [SUM_W-1:0]      addr_mod;

`ifdef BANK_LOAD_CHECKSUM_EN
  logic [15:0]           csum_d;
`endif

  // in_ready is a flop that always mirrors (state == LOAD && remaining != 0)
  assign hs = in_valid & in_ready;

  // Unreduced word address one bit wider than the bank address, then reduced
  assign addr_full = {1'b0, base_q} + word_q;
  assign addr_mod  = addr_full % DEPTH_S;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and write-port next values
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rem_d   = rem_q;
    bank_d  = bank_q;
    word_d  = word_q;
    wren_d  = 1'b0;
    cs_d    = '0;
    addr_d  = wr_addr;
    data_d  = wr_data;
    wrap_d  = wrap_err;
`ifdef BANK_LOAD_CHECKSUM_EN
    csum_d  = checksum;
`endif

    // A handshake can only happen in LOAD; the byte is written even on abort
    if (hs) begin
      wren_d = 1'b1;
      cs_d   = CS_ONE << bank_q;
      addr_d = ADDR_WIDTH'(addr_mod);
      data_d = in_data;
      if (addr_full >= DEPTH_S) begin
        wrap_d = 1'b1;
      end
      rem_d = rem_q - LEN_WIDTH'(1);
      if (bank_q == LAST_BANK) begin
        bank_d = '0;
        word_d = word_q + SUM_W'(1);
      end else begin
        bank_d = bank_q + BANK_W'(1);
      end
`ifdef BANK_LOAD_CHECKSUM_EN
      csum_d = checksum + 16'(in_data);
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          base_d = base_addr;
          rem_d  = len;
          bank_d = '0;
          word_d = '0;
          wrap_d = 1'b0;
`ifdef BANK_LOAD_CHECKSUM_EN
          csum_d = '0;
`endif
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs && (rem_q == LEN_WIDTH'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end

    ready_d = (state_d == S_LOAD) && (rem_d != '0);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      rem_q    <= '0;
      bank_q   <= '0;
      word_q   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wren     <= 1'b0;
      bank_cs  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wrap_err <= 1'b0;
`ifdef BANK_LOAD_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      base_q   <= base_d;
      rem_q    <= rem_d;
      bank_q   <= bank_d;
      word_q   <= word_d;
      in_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      wren     <= wren_d;
      bank_cs  <= cs_d;
      wr_addr  <= addr_d;
      wr_data  <= data_d;
      wrap_err <= wrap_d;
`ifdef BANK_LOAD_CHECKSUM_EN
      checksum <= csum_d;
`endif
    end
  end

endmodule
